// File: rtl/if_id_stage_pkg.sv
// Purpose: shared types and MIPS field positions for the IF/ID skid buffer and later decode stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_id_stage_pkg;

    // Skid-buffer occupancy; encoding is fixed so debug dumps read the entry count directly.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    // One held fetch result. PC+4 is stored rather than PC so the empty entry can report 0.
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } entry_t;

    // MIPS instruction field bit positions.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JADDR_MSB  = 25;
    localparam int JADDR_LSB  = 0;

endpackage

// File: rtl/if_id_stage_fields.sv
// Purpose: split a MIPS instruction word into its R/I/J-format fields.
// Latency: 0 cycles, pure wiring.
// Backpressure: none; combinational.
// Ports: i_instr in; o_opcode/o_rs/o_rt/o_rd/o_shamt/o_funct/o_imm16/o_jaddr out.
module mips_instr_fields
    import if_id_stage_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_funct,
    output logic [15:0] o_imm16,
    output logic [25:0] o_jaddr
);

    assign o_opcode = i_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_rs     = i_instr[RS_MSB:RS_LSB];
    assign o_rt     = i_instr[RT_MSB:RT_LSB];
    assign o_rd     = i_instr[RD_MSB:RD_LSB];
    assign o_shamt  = i_instr[SHAMT_MSB:SHAMT_LSB];
    assign o_funct  = i_instr[FUNCT_MSB:FUNCT_LSB];
    assign o_imm16  = i_instr[IMM_MSB:IMM_LSB];
    assign o_jaddr  = i_instr[JADDR_MSB:JADDR_LSB];

endmodule

// File: rtl/if_id_stage.sv
// Purpose: IF/ID pipeline register as a 2-entry in-order skid buffer with field decode of the head entry.
// Latency: 1 cycle from accepted push to head outputs when empty.
// Backpressure: in_ready is registered from occupancy only (low when full); flush empties the buffer.
// Ports: clk, rst_n; fetch side in_valid/in_ready/in_pc/in_instr; flush;
//        decode side out_valid/out_ready/out_pc_plus4/out_instr and decoded fields; stall_cnt.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] out_instr,
    output logic [5:0]  out_opcode,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_shamt,
    output logic [5:0]  out_funct,
    output logic [15:0] out_imm16,
    output logic [25:0] out_jaddr,
    output logic [15:0] stall_cnt
);

    localparam entry_t C_EMPTY_ENTRY = '{pc_plus4: 32'h0, instr: NOP_INSTR};

    state_e      r_state;
    state_e      w_state_nxt;
    entry_t      r_head;
    entry_t      r_tail;
    entry_t      w_head_nxt;
    entry_t      w_tail_nxt;
    entry_t      w_new;
    logic        r_in_ready;
    logic [15:0] r_stall_cnt;
    logic        w_push;
    logic        w_pop;

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != S_EMPTY);
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_new     = '{pc_plus4: in_pc + 32'd4, instr: in_instr};

    // Head is always entry 0; a vacated slot is rewritten with the empty entry so
    // the outputs show NOP/0 whenever nothing is held.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_head_nxt  = C_EMPTY_ENTRY;
            w_tail_nxt  = C_EMPTY_ENTRY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = S_ONE;
                        w_head_nxt  = w_new;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_head_nxt = w_new;
                    end else if (w_push) begin
                        w_state_nxt = S_TWO;
                        w_tail_nxt  = w_new;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                        w_head_nxt  = C_EMPTY_ENTRY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_state_nxt = S_ONE;
                        w_head_nxt  = r_tail;
                        w_tail_nxt  = C_EMPTY_ENTRY;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_head_nxt  = C_EMPTY_ENTRY;
                    w_tail_nxt  = C_EMPTY_ENTRY;
                end
            endcase
        end
    end

    // in_ready is a registered copy of "not full", so it stays low through reset
    // and rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_head      <= C_EMPTY_ENTRY;
            r_tail      <= C_EMPTY_ENTRY;
            r_in_ready  <= 1'b0;
            r_stall_cnt <= 16'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
            // Saturating; intentionally survives flush.
            if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign out_pc_plus4 = r_head.pc_plus4;
    assign out_instr    = r_head.instr;

    mips_instr_fields u_fields (
        .i_instr  (r_head.instr),
        .o_opcode (out_opcode),
        .o_rs     (out_rs),
        .o_rt     (out_rt),
        .o_rd     (out_rd),
        .o_shamt  (out_shamt),
        .o_funct  (out_funct),
        .o_imm16  (out_imm16),
        .o_jaddr  (out_jaddr)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// Purpose: directed self-checking bench for if_id_stage.
// Latency: n/a.
// Backpressure: n/a.
module tb_if_id_stage;

    localparam logic [31:0] TB_NOP = 32'h0000_0020;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [15:0] out_imm16;
    logic [25:0] out_jaddr;
    logic [15:0] stall_cnt;

    int n_checks;
    int n_pass;

    if_id_stage #(.NOP_INSTR(TB_NOP)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .out_opcode   (out_opcode),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_shamt    (out_shamt),
        .out_funct    (out_funct),
        .out_imm16    (out_imm16),
        .out_jaddr    (out_jaddr),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit so samples/drives sit away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (2) step();
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
        check("rst_out_instr", out_instr, TB_NOP);
        check("rst_pc_plus4", out_pc_plus4, 32'h0);
        check("rst_funct", {26'h0, out_funct}, 32'h20);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("post_rst_out_valid", {31'h0, out_valid}, 32'h0);

        // Single push, decode of addi $t0,$0,-5
        out_ready = 1'b1;
        offer(1'b1, 32'h0040_0000, 32'h2008_FFFB);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check("t1_out_valid", {31'h0, out_valid}, 32'h1);
        check("t1_pc_plus4", out_pc_plus4, 32'h0040_0004);
        check("t1_opcode", {26'h0, out_opcode}, 32'h08);
        check("t1_rs", {27'h0, out_rs}, 32'h0);
        check("t1_rt", {27'h0, out_rt}, 32'h8);
        check("t1_imm16", {16'h0, out_imm16}, 32'hFFFB);
        check("t1_jaddr", {6'h0, out_jaddr}, 32'h0008_FFFB);
        check("t1_stall", {16'h0, stall_cnt}, 32'h0);
        step();
        check("t1_pop_empty", {31'h0, out_valid}, 32'h0);
        check("t1_pop_nop", out_instr, TB_NOP);

        // Push with simultaneous pop in ONE stays ONE with the new head
        offer(1'b1, 32'h0000_0200, 32'h0000_5025);
        step();
        offer(1'b1, 32'h0000_0204, 32'h0128_5020);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check("pp_out_valid", {31'h0, out_valid}, 32'h1);
        check("pp_in_ready", {31'h0, in_ready}, 32'h1);
        check("pp_instr", out_instr, 32'h0128_5020);
        check("pp_rd", {27'h0, out_rd}, 32'h0A);
        check("pp_rs", {27'h0, out_rs}, 32'h09);
        check("pp_pc_plus4", out_pc_plus4, 32'h0000_0208);
        step();
        check("pp_drained", {31'h0, out_valid}, 32'h0);

        // Fill under backpressure, third offer held off, then drain in order
        out_ready = 1'b0;
        offer(1'b1, 32'h0000_0100, 32'h1111_1111);
        step();
        check("bp_in_ready_1", {31'h0, in_ready}, 32'h1);
        check("bp_stall_1", {16'h0, stall_cnt}, 32'h0);
        offer(1'b1, 32'h0000_0104, 32'h2222_2222);
        step();
        check("bp_in_ready_2", {31'h0, in_ready}, 32'h0);
        check("bp_stall_2", {16'h0, stall_cnt}, 32'h1);
        check("bp_head_2", out_instr, 32'h1111_1111);
        offer(1'b1, 32'h0000_0108, 32'h3333_3333);
        step();
        step();
        check("bp_stall_4", {16'h0, stall_cnt}, 32'h3);
        check("bp_head_stable", out_instr, 32'h1111_1111);
        check("bp_head_pc", out_pc_plus4, 32'h0000_0104);
        offer(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        check("bp_pop1_instr", out_instr, 32'h2222_2222);
        check("bp_pop1_pc", out_pc_plus4, 32'h0000_0108);
        check("bp_pop1_in_ready", {31'h0, in_ready}, 32'h1);
        check("bp_pop1_stall", {16'h0, stall_cnt}, 32'h3);
        step();
        check("bp_pop2_empty", {31'h0, out_valid}, 32'h0);

        // Flush in TWO with a simultaneous offer; stall_cnt survives
        out_ready = 1'b0;
        offer(1'b1, 32'h0000_0300, 32'h4444_4444);
        step();
        offer(1'b1, 32'h0000_0304, 32'h5555_5555);
        step();
        check("fl_stall_pre", {16'h0, stall_cnt}, 32'h4);
        flush = 1'b1;
        offer(1'b1, 32'h0000_0308, 32'h6666_6666);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("fl_out_valid", {31'h0, out_valid}, 32'h0);
        check("fl_out_instr", out_instr, TB_NOP);
        check("fl_in_ready", {31'h0, in_ready}, 32'h1);
        check("fl_stall_kept", {16'h0, stall_cnt}, 32'h5);
        step();
        check("fl_push_dropped", {31'h0, out_valid}, 32'h0);

        // PC+4 wrap
        out_ready = 1'b1;
        offer(1'b1, 32'hFFFF_FFFC, 32'h0800_0010);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check("wrap_valid", {31'h0, out_valid}, 32'h1);
        check("wrap_pc_plus4", out_pc_plus4, 32'h0000_0000);
        check("wrap_jaddr", {6'h0, out_jaddr}, 32'h0000_0010);
        step();

        // Asynchronous reset while full
        out_ready = 1'b0;
        offer(1'b1, 32'h0000_0400, 32'h7777_7777);
        step();
        offer(1'b1, 32'h0000_0404, 32'h8888_8888);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check("ar_stall_pre", {16'h0, stall_cnt}, 32'h6);
        check("ar_full", {31'h0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", {31'h0, out_valid}, 32'h0);
        check("ar_stall_cnt", {16'h0, stall_cnt}, 32'h0);
        check("ar_out_instr", out_instr, TB_NOP);
        #2;
        rst_n = 1'b1;
        step();
        check("ar_in_ready", {31'h0, in_ready}, 32'h1);
        check("ar_discarded", {31'h0, out_valid}, 32'h0);

        // Long stall saturation
        offer(1'b1, 32'h0000_0500, 32'h9999_9999);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check("sat_start", {16'h0, stall_cnt}, 32'h0);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", {16'h0, stall_cnt}, 32'hFFFE);
        step();
        check("sat_ffff", {16'h0, stall_cnt}, 32'hFFFF);
        repeat (4464) @(posedge clk);
        #1;
        check("sat_hold", {16'h0, stall_cnt}, 32'hFFFF);
        check("sat_head_stable", out_instr, 32'h9999_9999);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word presented on out_instr while no entry is held.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  fetch side offers an instruction this cycle.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 in_pc  input  32  byte address of the offered instruction.
REQ-007 in_instr  input  32  offered MIPS instruction word.
REQ-008 flush  input  1  discard all held entries (taken branch/jump).
REQ-009 out_valid  output  1  head entry is valid for decode.
REQ-010 out_ready  input  1  decode/sign-extend stage consumes the head entry this cycle.
REQ-011 out_pc_plus4  output  32  head PC + 4, modulo 2^32.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_opcode/out_rs/out_rt/out_rd/out_shamt/out_funct  output  6/5/5/5/5/6  fields [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0] of out_instr.
REQ-014 out_imm16  output  16  out_instr[15:0]; the operand for the 16-to-32 sign extender.
REQ-015 out_jaddr  output  26  out_instr[25:0].
REQ-016 stall_cnt  output  16  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 The stage SHALL be a 2-entry in-order skid buffer with states EMPTY, ONE, TWO.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, driven from state only (no combinational path from out_ready).
REQ-019 A push SHALL occur when in_valid=1 and in_ready=1; a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 Transitions: EMPTY+push -> ONE; ONE+push+pop -> ONE; ONE+push -> TWO; ONE+pop -> EMPTY; TWO+pop -> ONE; otherwise hold.
REQ-021 out_valid SHALL be 1 exactly in states ONE and TWO.
REQ-022 Latency: an instruction pushed at edge N SHALL appear on the outputs after edge N (1 cycle) when the buffer was EMPTY.
REQ-023 Order SHALL be preserved; the head entry SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 In EMPTY, out_instr SHALL equal NOP_INSTR, out_pc_plus4 SHALL be 0, and all decoded fields SHALL derive from NOP_INSTR.
REQ-025 out_pc_plus4 SHALL wrap: in_pc=32'hFFFF_FFFC yields 32'h0000_0000.
REQ-026 flush=1 SHALL force the next state to EMPTY, overriding any simultaneous push or pop; a push in the flush cycle SHALL be dropped.
REQ-027 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, SHALL saturate at 16'hFFFF, and SHALL not be cleared by flush.
REQ-028 All decoded field outputs SHALL be pure wiring from the registered head entry (no additional latency).

Reset
REQ-029 rst_n=0 SHALL immediately force state EMPTY, out_valid=0, in_ready=0 while asserted, stall_cnt=0, entries cleared to NOP_INSTR/PC 0.
REQ-030 in_ready SHALL rise in the first cycle after rst_n deasserts; reset mid-operation SHALL discard all held entries.

Structure
REQ-031 A shared package SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the MIPS field-position constants.
REQ-032 Field extraction SHALL be one sub-module, mips_instr_fields, instantiated on the head entry and reusable by later stages.

Verification
REQ-033 Push pc=32'h0040_0000, instr=32'h2008_FFFB with out_ready=1 -> next cycle out_valid=1, out_pc_plus4=32'h0040_0004, out_opcode=6'h08, out_rt=5'd8, out_imm16=16'hFFFB.
REQ-034 Three pushes with out_ready=0 -> in_ready=0 after the second, third held off, stall_cnt counts each stalled cycle; release out_ready -> entries pop in order.
REQ-035 State TWO plus flush with simultaneous in_valid=1 -> next cycle state EMPTY, out_valid=0, out_instr=NOP_INSTR, in_ready=1.
REQ-036 Push in_pc=32'hFFFF_FFFC -> out_pc_plus4=32'h0000_0000.
REQ-037 Drop rst_n asynchronously mid-cycle while in TWO -> out_valid=0 and stall_cnt=0 before the next clk edge.
REQ-038 Hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt saturates at 16'hFFFF.
